or_nway_reduce: RTL and testbench

//  Parametrised, pipelined N-way OR reduction; successor to the fixed 8-way combinational OR.

---
 rtl/or_pkg.sv | 44 ++++
 rtl/or_tree_node.sv | 43 ++++
 rtl/or_nway_reduce.sv | 93 +++++++++
 tb/tb_or_nway_reduce.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/or_pkg.sv
// Shared types and elaboration-time helpers for the pipelined N-way OR reduction.
package or_pkg;

  // Widest lowest-set-bit index carried between tree nodes (supports WIDTH up to 65536).
  localparam int unsigned OR_IDXW_MAX = 16;

  // Payload passed from one tree level to the next.
  typedef struct packed {
    logic                   y;
    logic [OR_IDXW_MAX-1:0] idx;
  } or_node_t;

  // Smallest L with b**L >= n (number of tree levels).
  function automatic int unsigned clog_base(input int unsigned n, input int unsigned b);
    int unsigned l = 0;
    int unsigned p = 1;
    while (p < n) begin
      p = p * b;
      l = l + 1;
    end
    return l;
  endfunction

  // Integer power b**e.
  function automatic int unsigned pow_int(input int unsigned b, input int unsigned e);
    int unsigned p = 1;
    for (int unsigned i = 0; i < e; i++) p = p * b;
    return p;
  endfunction

  // Width of an index into a WIDTH-bit word, at least one bit.
  function automatic int unsigned idx_w(input int unsigned width);
    return (width > 1) ? 32'($clog2(width)) : 32'd1;
  endfunction

  // Flat-array offset of the first node of a given level (level 0 = leaves).
  function automatic int unsigned node_off(input int unsigned level, input int unsigned fanin,
                                           input int unsigned levels);
    int unsigned off = 0;
    for (int unsigned m = 0; m < level; m++) off = off + pow_int(fanin, levels - 1 - m);
    return off;
  endfunction

endpackage

// File: rtl/or_tree_node.sv
// One registered FANIN-way OR node with lowest-set-child index select.
module or_tree_node
  import or_pkg::*;
#(
  parameter int unsigned FANIN  = 4,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned IDXW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [FANIN-1:0]     kid_valid,
  input  or_node_t [FANIN-1:0] kids,
  output logic                 valid,
  output or_node_t             node
);

  localparam int unsigned SELW = $clog2(FANIN);

  or_node_t nxt;

  // OR of children; descending scan so the lowest-numbered set child wins.
  always_comb begin
    nxt = '0;
    for (int i = FANIN - 1; i >= 0; i--) begin
      if (kids[SELW'(i)].y) begin
        nxt.y   = 1'b1;
        nxt.idx = OR_IDXW_MAX'(IDXW'(32'(i) * STRIDE + 32'(kids[SELW'(i)].idx)));
      end
    end
  end

  // Stage register: valid always advances, data loads only on a valid beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      node  <= '0;
    end else begin
      valid <= |kid_valid;
      if (|kid_valid) node <= nxt;
    end
  end

endmodule

// File: rtl/or_nway_reduce.sv
// Pipelined N-way OR reduction with lowest-set-bit index; latency = LEVELS.
// Optional sticky "any hit since clear" flag built when OR_STICKY_EN is defined.
module or_nway_reduce
  import or_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FANIN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  output logic                     y,
  output logic                     zero,
  output logic [$clog2(WIDTH)-1:0] first_idx,
  input  logic                     sticky_clr,
  output logic                     sticky
);

  localparam int unsigned LEVELS = (clog_base(WIDTH, FANIN) < 1) ? 1 : clog_base(WIDTH, FANIN);
  localparam int unsigned PW     = pow_int(FANIN, LEVELS);
  localparam int unsigned IDXW   = idx_w(WIDTH);
  localparam int unsigned NTOT   = node_off(LEVELS, FANIN, LEVELS);
  localparam int unsigned ROOT   = NTOT - 1;

  // Zero padding up to a full tree; pad bits can never set y or win the index.
  logic [PW-1:0] padded;
  assign padded = PW'(in_data);

  or_node_t node_q [NTOT];
  logic     node_v [NTOT];

  // Tree of registered nodes, leaves first, root last in the flat arrays.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned CNT    = pow_int(FANIN, LEVELS - 1 - l);
    localparam int unsigned OFF    = node_off(l, FANIN, LEVELS);
    localparam int unsigned STRIDE = pow_int(FANIN, l);
    for (genvar k = 0; k < CNT; k++) begin : g_node
      or_node_t [FANIN-1:0] kids;
      logic [FANIN-1:0]     kv;
      for (genvar i = 0; i < FANIN; i++) begin : g_kid
        if (l == 0) begin : g_leaf
          assign kids[i] = '{y: padded[k*FANIN+i], idx: '0};
          assign kv[i]   = in_valid;
        end else begin : g_inner
          assign kids[i] = node_q[node_off(l - 1, FANIN, LEVELS) + k*FANIN + i];
          assign kv[i]   = node_v[node_off(l - 1, FANIN, LEVELS) + k*FANIN + i];
        end
      end
      or_tree_node #(
        .FANIN (FANIN),
        .STRIDE(STRIDE),
        .IDXW  (IDXW)
      ) u_node (
        .clk      (clk),
        .reset    (reset),
        .kid_valid(kv),
        .kids     (kids),
        .valid    (node_v[OFF+k]),
        .node     (node_q[OFF+k])
      );
    end
  end

  // Outputs come straight from the root stage flops.
  assign out_valid = node_v[ROOT];
  assign y         = node_q[ROOT].y;
  assign zero      = node_v[ROOT] & ~node_q[ROOT].y;
  assign first_idx = node_q[ROOT].idx[$clog2(WIDTH)-1:0];

  logic unused_idx;
  assign unused_idx = ^node_q[ROOT].idx;

`ifdef OR_STICKY_EN
  logic sticky_q;

  // Sticky hit flag; a hit in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset)                  sticky_q <= 1'b0;
    else if (out_valid && y)    sticky_q <= 1'b1;
    else if (sticky_clr)        sticky_q <= 1'b0;
  end

  assign sticky = sticky_q;
`else
  assign sticky = 1'b0;

  logic unused_clr;
  assign unused_clr = sticky_clr;
`endif

endmodule

// File: tb/tb_or_nway_reduce.sv
// Directed bench for or_nway_reduce (16/4 default instance plus an 8/2 instance).
module tb_or_nway_reduce;

`ifdef OR_STICKY_EN
  localparam bit STICKY_EN = 1'b1;
`else
  localparam bit STICKY_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        y;
  logic        zero;
  logic [3:0]  first_idx;
  logic        sticky_clr;
  logic        sticky;

  logic        in_valid8;
  logic [7:0]  in_data8;
  logic        out_valid8;
  logic        y8;
  logic        zero8;
  logic [2:0]  first_idx8;
  logic        sticky8;

  int compared   = 0;
  int mismatched = 0;

  or_nway_reduce #(.WIDTH(16), .FANIN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .y         (y),
    .zero      (zero),
    .first_idx (first_idx),
    .sticky_clr(sticky_clr),
    .sticky    (sticky)
  );

  or_nway_reduce #(.WIDTH(8), .FANIN(2)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid8),
    .in_data   (in_data8),
    .out_valid (out_valid8),
    .y         (y8),
    .zero      (zero8),
    .first_idx (first_idx8),
    .sticky_clr(1'b0),
    .sticky    (sticky8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic yy, input logic z,
                         input logic [3:0] idx);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".y"},         32'(y),         32'(yy));
    chk({tag, ".zero"},      32'(zero),      32'(z));
    chk({tag, ".first_idx"}, 32'(first_idx), 32'(idx));
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b1;
    in_data    = 16'hFFFF;
    sticky_clr = 1'b0;
    in_valid8  = 1'b1;
    in_data8   = 8'hFF;

    // Reset held 3 cycles with a live all-ones beat at the input.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out("rst", 1'b0, 1'b0, 1'b0, 4'd0);
      chk("rst.sticky", 32'(sticky), 32'd0);
      chk("rst.out_valid8", 32'(out_valid8), 32'd0);
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_out("post_rst", 1'b0, 1'b0, 1'b0, 4'd0);
      chk("post_rst.sticky", 32'(sticky), 32'd0);
    end

    // Single all-zero beat: latency 2, one-cycle pulse, zero forced low when idle.
    in_valid = 1'b1; in_data = 16'h0000;
    tick();
    in_valid = 1'b0;
    chk("zero_beat.early", 32'(out_valid), 32'd0);
    tick();
    chk_out("zero_beat", 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    chk_out("zero_beat.after", 1'b0, 1'b0, 1'b0, 4'd0);

    // Back-to-back beats.
    in_valid = 1'b1; in_data = 16'h0001;
    tick();
    in_data = 16'h8000;
    tick();
    chk_out("b2b0", 1'b1, 1'b1, 1'b0, 4'd0);
    in_data = 16'h0550;
    tick();
    chk_out("b2b1", 1'b1, 1'b1, 1'b0, 4'd15);
    in_valid = 1'b0;
    tick();
    chk_out("b2b2", 1'b1, 1'b1, 1'b0, 4'd4);
    tick();
    chk_out("b2b.hold", 1'b0, 1'b1, 1'b0, 4'd4);

    // Gaps preserved.
    in_valid = 1'b1; in_data = 16'h0010;
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("gap0", 1'b1, 1'b1, 1'b0, 4'd4);
    tick();
    chk_out("gap.idle1", 1'b0, 1'b1, 1'b0, 4'd4);
    in_valid = 1'b1; in_data = 16'h0200;
    tick();
    in_valid = 1'b0;
    chk_out("gap.idle2", 1'b0, 1'b1, 1'b0, 4'd4);
    tick();
    chk_out("gap1", 1'b1, 1'b1, 1'b0, 4'd9);
    tick();
    chk_out("gap1.after", 1'b0, 1'b1, 1'b0, 4'd9);

    // 8-bit, fanin-2 instance: latency 3.
    in_valid8 = 1'b1; in_data8 = 8'h80;
    tick();
    in_valid8 = 1'b0;
    chk("w8.c1.out_valid", 32'(out_valid8), 32'd0);
    tick();
    chk("w8.c2.out_valid", 32'(out_valid8), 32'd0);
    tick();
    chk("w8.out_valid", 32'(out_valid8), 32'd1);
    chk("w8.y", 32'(y8), 32'd1);
    chk("w8.zero", 32'(zero8), 32'd0);
    chk("w8.first_idx", 32'(first_idx8), 32'd7);
    chk("w8.sticky", 32'(sticky8), 32'd0);
    tick();
    chk("w8.after", 32'(out_valid8), 32'd0);

    // In-flight beat discarded by reset.
    in_valid = 1'b1; in_data = 16'hFFFF;
    tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    chk_out("flush.rst", 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_out("flush.after", 1'b0, 1'b0, 1'b0, 4'd0);
    end

    // Sticky behaviour (tied low when the feature is not built).
    in_valid = 1'b1; in_data = 16'h0000;
    tick();
    in_data = 16'h0100;
    tick();
    in_data = 16'h0000;
    tick();
    in_valid = 1'b0;
    chk("sticky.s0", 32'(sticky), 32'd0);
    chk("sticky.idx8", 32'(first_idx), 32'd8);
    tick();
    chk("sticky.s1", 32'(sticky), 32'(STICKY_EN));
    tick();
    chk("sticky.s2", 32'(sticky), 32'(STICKY_EN));
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky.clr", 32'(sticky), 32'd0);
    in_valid = 1'b1; in_data = 16'h0002;
    tick();
    in_valid = 1'b0;
    tick();
    chk_out("sticky.hit", 1'b1, 1'b1, 1'b0, 4'd1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky.hit_wins", 32'(sticky), 32'(STICKY_EN));
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky.clr2", 32'(sticky), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
